vi_tx_frame_scheduler: RTL

//  Sequences and shares the single UART transmitter of the button/LED virtual interface.
//  Two requesters compete for it: a periodic LED-state sync and a command acknowledgement.

---
 rtl/vi_tx_frame_scheduler_pkg.sv | 14 +
 rtl/vi_tx_frame_scheduler_sync_timer.sv | 16 +
 rtl/vi_tx_frame_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/vi_tx_frame_scheduler_pkg.sv
// vi_tx_frame_scheduler_pkg: shared FSM state encoding, default frame tags and frame length
// for the button/LED virtual interface (also used by the RX command decoder).
package vi_tx_frame_scheduler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_TAG,
    ST_WAIT_TAG,
    ST_SEND_PAY,
    ST_WAIT_PAY
  } state_t;
  localparam logic [7:0] TAG_LED_DEF = 8'h4C;
  localparam logic [7:0] TAG_ACK_DEF = 8'h41;
  localparam int         FRAME_LEN   = 2;
endpackage

// File: rtl/vi_tx_frame_scheduler_sync_timer.sv
// vi_sync_timer: free-running wrap counter 0..CLKS-1, o_tick high during the terminal count.
// Ports: i_clk clock, i_rst_n async active-low reset, o_tick terminal-count strobe.
module vi_sync_timer #(
  parameter int CLKS = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int W = $clog2(CLKS);
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(CLKS - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= o_tick ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/vi_tx_frame_scheduler.sv
// vi_tx_frame_scheduler: shares one uart_tx between periodic LED sync and command-ack frames,
// each sent as [TAG][PAYLOAD] over the tx_dv/tx_done byte handshake.
// Ports: i_clk, i_rst_n (async active-low); i_leds live LED state; i_ack_req/i_ack_byte ack
// request; o_ack_busy ack in flight; o_tx_dv/o_tx_byte to uart_tx; i_tx_active/i_tx_done from
// uart_tx; o_frame_done pulse after a frame's payload completes.
// Optional: `SEND_ON_CHANGE_EN also requests an LED frame whenever leds differ from last sent.
module vi_tx_frame_scheduler
  import vi_tx_frame_scheduler_pkg::*;
#(
  parameter int         CLKS_PER_SYNC = 1000,
  parameter logic [7:0] TAG_LED       = TAG_LED_DEF,
  parameter logic [7:0] TAG_ACK       = TAG_ACK_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_leds,
  input  logic       i_ack_req,
  input  logic [7:0] i_ack_byte,
  output logic       o_ack_busy,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_frame_done
);
  state_t     r_state, w_next;
  logic       r_sync_pend, r_ack_pend, r_is_ack, r_ack_busy, r_tx_dv, r_frame_done;
  logic [7:0] r_ack_reg, r_pay, r_tx_byte;
  logic       w_tick, w_start, w_start_ack, w_start_led, w_ack_acc, w_sync_set, w_pay_done;
`ifdef SEND_ON_CHANGE_EN
  logic [7:0] r_last_sent;
`endif
  vi_sync_timer #(.CLKS(CLKS_PER_SYNC)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .o_tick (w_tick)
  );
  always_comb begin
    w_start     = r_state == ST_IDLE && !i_tx_active && (r_ack_pend || r_sync_pend);
    w_start_ack = w_start && r_ack_pend;
    w_start_led = w_start && !r_ack_pend;
    w_ack_acc   = i_ack_req && !r_ack_busy;
    w_pay_done  = r_state == ST_WAIT_PAY && i_tx_done;
`ifdef SEND_ON_CHANGE_EN
    // An LED frame under construction (selection cycle included) already reports leds.
    w_sync_set  = w_tick || (i_leds != r_last_sent && !w_start_led &&
                             !(r_state != ST_IDLE && !r_is_ack));
`else
    w_sync_set  = w_tick;
`endif
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = w_start ? ST_SEND_TAG : ST_IDLE;
      ST_SEND_TAG: w_next = ST_WAIT_TAG;
      ST_WAIT_TAG: w_next = i_tx_done ? ST_SEND_PAY : ST_WAIT_TAG;
      ST_SEND_PAY: w_next = ST_WAIT_PAY;
      ST_WAIT_PAY: w_next = i_tx_done ? ST_IDLE : ST_WAIT_PAY;
      default:     w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_sync_pend  <= 1'b0;
      r_ack_pend   <= 1'b0;
      r_is_ack     <= 1'b0;
      r_ack_busy   <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_frame_done <= 1'b0;
      r_ack_reg    <= '0;
      r_pay        <= '0;
      r_tx_byte    <= '0;
    end else begin
      r_state      <= w_next;
      // A terminal count coinciding with an LED frame start keeps the request pending.
      r_sync_pend  <= w_sync_set || (r_sync_pend && !w_start_led);
      r_ack_pend   <= w_ack_acc || (r_ack_pend && !w_start_ack);
      r_ack_busy   <= w_ack_acc || (r_ack_busy && !(w_pay_done && r_is_ack));
      r_tx_dv      <= r_state == ST_SEND_TAG || r_state == ST_SEND_PAY;
      r_frame_done <= w_pay_done;
      if (w_ack_acc) r_ack_reg <= i_ack_byte;
      if (w_start) begin
        r_is_ack <= r_ack_pend;
        r_pay    <= r_ack_pend ? r_ack_reg : i_leds;
      end
      if (r_state == ST_SEND_TAG)      r_tx_byte <= r_is_ack ? TAG_ACK : TAG_LED;
      else if (r_state == ST_SEND_PAY) r_tx_byte <= r_pay;
    end
`ifdef SEND_ON_CHANGE_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)         r_last_sent <= '0;
    else if (w_start_led) r_last_sent <= i_leds;
`endif
  assign o_ack_busy   = r_ack_busy;
  assign o_tx_dv      = r_tx_dv;
  assign o_tx_byte    = r_tx_byte;
  assign o_frame_done = r_frame_done;
endmodule
